// File: rtl/serial_full_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// ovf and its modport entries exist only with SERIAL_ADDER_OVERFLOW_EN.
interface serial_full_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first.
// SERIAL_ADDER_OVERFLOW_EN adds a signed-overflow result (ovf).
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_full_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c_next;
    logic             last;

    assign s      = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // acc accumulates privately so sum never shows partial bits
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            acc    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    acc   <= {s, acc[WIDTH-1:1]};
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum_q  <= {s, acc[WIDTH-1:1]};
                        cout_q <= c_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf_q;

    // carry still holds the carry into the MSB on the final cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == SHIFT && last) begin
            ovf_q <= carry ^ c_next;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_full_adder.sv
// Scoreboard bench for serial_full_adder (WIDTH=8), directed vectors.
// Overflow checks build only with SERIAL_ADDER_OVERFLOW_EN.
module tb_serial_full_adder;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    serial_full_adder_if #(.WIDTH(W)) bus ();

    serial_full_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no op");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_sum", 32'(bus.sum), 32'(e.sum));
                chk("mon_cout", 32'(bus.cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVERFLOW_EN
                chk("mon_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] es,
                          input logic ec, input logic eo, input bit noise);
        int nb;
        bit seen;
        exp_t e;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        sb.push_back(e);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nb   = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1;
            end else begin
                if (bus.busy === 1'b1) nb++;
                if (noise) begin
                    bus.start = 1'b1;
                    bus.a     = (i % 2) ? 8'hAA : 8'h55;
                    bus.b     = (i % 2) ? 8'hAA : 8'h55;
                    bus.cin   = i[0];
                end
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(nb), 32'(W));
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("hold_sum", 32'(bus.sum), 32'(es));
        chk("hold_cout", 32'(bus.cout), 32'(ec));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.start = 1'($urandom);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cin   = 1'($urandom);
            @(negedge clk);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("quiet_busy", 32'(bus.busy), 32'd0);
        end

        run_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("persist_sum", 32'(bus.sum), 32'h41);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1);
        repeat (W + 4) @(negedge clk);
        chk("no_second_op", 32'(bus.sum), 32'h46);

        bus.a     = 8'h80;
        bus.b     = 8'h80;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        repeat (W + 4) @(negedge clk);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("ovf_hold", 32'(bus.ovf), 32'd0);
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
